// File: rtl/dca_matrix_load_row_packer_pkg.sv
// Shared definitions for the matrix load row packer: FSM state encoding,
// row/beat width derivation and the zero fill value for padded tensor rows.
package dca_matrix_load_row_packer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_PAD  = 2'd2;
  localparam logic [1:0] ST_EMIT = 2'd3;

  // Replicated across the row width wherever a zero tensor row is needed.
  localparam logic TENSOR_ZERO = 1'b0;

  // Row counter must hold the value MATRIX_SIZE itself (commanded row count).
  function automatic int calc_row_cnt_w(input int matrix_size);
    return $clog2(matrix_size + 1);
  endfunction

  function automatic int calc_num_beat(input int matrix_size, input int bw_scalar,
                                       input int bw_beat);
    return (matrix_size * bw_scalar) / bw_beat;
  endfunction

endpackage

// File: rtl/dca_row_beat_assembler.sv
// Assembles NUM_BEAT memory beats into one tensor row buffer; beat k lands in
// bits [k*BW_BEAT +: BW_BEAT]. A zero request wipes the whole row in one cycle.
module dca_row_beat_assembler
  import dca_matrix_load_row_packer_pkg::*;
#(
  parameter int BW_BEAT  = 32,
  parameter int NUM_BEAT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        beat_we,
  input  logic                        row_zero,
  input  logic [BW_BEAT-1:0]          beat_data,
  output logic [NUM_BEAT*BW_BEAT-1:0] row_data,
  output logic                        beat_last
);

  localparam int BW_ROW      = NUM_BEAT * BW_BEAT;
  localparam int BW_BEAT_CNT = (NUM_BEAT > 1) ? $clog2(NUM_BEAT) : 1;
  localparam logic [BW_BEAT_CNT-1:0] LAST_BEAT = BW_BEAT_CNT'(NUM_BEAT - 1);

  logic [BW_BEAT_CNT-1:0] beat_cnt;

  assign beat_last = (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      row_data <= {BW_ROW{TENSOR_ZERO}};
    end else if (clear) begin
      beat_cnt <= '0;
      row_data <= {BW_ROW{TENSOR_ZERO}};
    end else if (beat_we) begin
      row_data[beat_cnt*BW_BEAT +: BW_BEAT] <= beat_data;
      beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
    end else if (row_zero) begin
      row_data <= {BW_ROW{TENSOR_ZERO}};
    end
  end

endmodule

// File: rtl/dca_matrix_load_row_packer.sv
// Packs memory read beats into MATRIX_SIZE tensor rows per command, zero-padding
// rows past the commanded count. Optional stall counter: DCA_LOAD_ROW_PACKER_STALL_CNT_EN.
module dca_matrix_load_row_packer
  import dca_matrix_load_row_packer_pkg::*;
#(
  parameter  int MATRIX_SIZE_PARA = 8,
  parameter  int BW_TENSOR_SCALAR = 8,
  parameter  int BW_BEAT          = 32,
  localparam int MATRIX_SIZE      = MATRIX_SIZE_PARA,
  localparam int BW_TENSOR_ROW    = MATRIX_SIZE_PARA * BW_TENSOR_SCALAR,
  localparam int NUM_BEAT         = calc_num_beat(MATRIX_SIZE_PARA, BW_TENSOR_SCALAR, BW_BEAT),
  localparam int BW_ROW_CNT       = calc_row_cnt_w(MATRIX_SIZE_PARA)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     enable,
  output logic                     busy,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [BW_ROW_CNT-1:0]    cmd_num_rows,
  input  logic                     beat_valid,
  output logic                     beat_ready,
  input  logic [BW_BEAT-1:0]       beat_data,
  output logic                     load_tensor_row_wvalid,
  input  logic                     load_tensor_row_wready,
  output logic                     load_tensor_row_wlast,
  output logic [BW_TENSOR_ROW-1:0] load_tensor_row_wdata
`ifdef DCA_LOAD_ROW_PACKER_STALL_CNT_EN
  ,
  output logic [31:0]              stall_cycles
`endif
);

  localparam logic [BW_ROW_CNT-1:0] ROW_MAX  = BW_ROW_CNT'(MATRIX_SIZE);
  localparam logic [BW_ROW_CNT-1:0] ROW_LAST = BW_ROW_CNT'(MATRIX_SIZE - 1);

  function automatic logic [BW_ROW_CNT-1:0] clamp_rows(input logic [BW_ROW_CNT-1:0] n);
    return (n > ROW_MAX) ? ROW_MAX : n;
  endfunction

  logic [1:0]            state;
  logic [BW_ROW_CNT-1:0] row_cnt;
  logic [BW_ROW_CNT-1:0] num_rows;
  logic [BW_ROW_CNT-1:0] cmd_rows;
  logic [BW_ROW_CNT-1:0] row_nxt;
  logic                  active;
  logic                  cmd_fire;
  logic                  beat_fire;
  logic                  row_fire;
  logic                  pad_go;
  logic                  beat_last;
  logic [BW_TENSOR_ROW-1:0] row_data;

  // Clear outranks every handshake, so no ready/valid is shown while it is high.
  assign active     = enable & ~clear;
  assign cmd_ready  = active && (state == ST_IDLE);
  assign beat_ready = active && (state == ST_FILL);
  assign load_tensor_row_wvalid = active && (state == ST_EMIT);
  assign load_tensor_row_wlast  = (state == ST_EMIT) && (row_cnt == ROW_LAST);
  assign load_tensor_row_wdata  = row_data;
  assign busy       = (state != ST_IDLE);

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign beat_fire = beat_valid & beat_ready;
  assign row_fire  = load_tensor_row_wvalid & load_tensor_row_wready;
  assign pad_go    = active && (state == ST_PAD);
  assign cmd_rows  = clamp_rows(cmd_num_rows);
  assign row_nxt   = row_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      row_cnt  <= '0;
      num_rows <= '0;
    end else if (clear) begin
      state    <= ST_IDLE;
      row_cnt  <= '0;
      num_rows <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            num_rows <= cmd_rows;
            row_cnt  <= '0;
            state    <= (cmd_rows == '0) ? ST_PAD : ST_FILL;
          end
        end
        ST_FILL: begin
          if (beat_fire && beat_last) state <= ST_EMIT;
        end
        ST_PAD: begin
          if (pad_go) state <= ST_EMIT;
        end
        ST_EMIT: begin
          if (row_fire) begin
            if (row_cnt == ROW_LAST) begin
              row_cnt <= '0;
              state   <= ST_IDLE;
            end else begin
              row_cnt <= row_nxt;
              state   <= (row_nxt < num_rows) ? ST_FILL : ST_PAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dca_row_beat_assembler #(
    .BW_BEAT  (BW_BEAT),
    .NUM_BEAT (NUM_BEAT)
  ) u_row_beat_assembler (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .beat_we   (beat_fire),
    .row_zero  (pad_go),
    .beat_data (beat_data),
    .row_data  (row_data),
    .beat_last (beat_last)
  );

`ifdef DCA_LOAD_ROW_PACKER_STALL_CNT_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // wvalid already carries enable, so disabled cycles never count as stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (clear) begin
      stall_cycles <= '0;
    end else if (load_tensor_row_wvalid && !load_tensor_row_wready) begin
      stall_cycles <= sat_inc32(stall_cycles);
    end
  end
`endif

endmodule
